// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall
// detection for the 5-stage LEGv8 pipeline, driven from a private shadow
// pipeline of destination-register info (EX, MEM, WB).
// Optional build macro FWD_HAZARD_STATS_EN adds saturating stall_count and
// fwd_count statistics outputs.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_use_rn,
  input  logic                  id_use_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  ex_bubble
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           fwd_count
`endif
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

  // Full instruction info needed while the instruction sits in EX
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rm;
    logic                  use_rn;
    logic                  use_rm;
  } ex_stage_t;

  // MEM and WB only ever act as forwarding sources, so only the destination
  // info is carried past EX
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } dst_stage_t;

  ex_stage_t  ex_q;
  ex_stage_t  ex_d;
  dst_stage_t mem_q;
  dst_stage_t wb_q;

  logic load_use;
  logic mem_src;
  logic wb_src;

  // Load-use hazard between the ID instruction and a load sitting in EX
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != ZR) & id_valid &
               ((id_use_rn & (id_rn == ex_q.rd)) |
                (id_use_rm & (id_rm == ex_q.rd)));
    stall    = load_use & ~flush;
  end

  // Next EX contents: a zeroed bubble unless a live instruction is admitted
  always_comb begin
    ex_d = '0;
    if (!(stall | flush | ~id_valid)) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.rn        = id_rn;
      ex_d.rm        = id_rm;
      ex_d.use_rn    = id_use_rn;
      ex_d.use_rm    = id_use_rm;
    end
  end

  // Shadow pipeline advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_q  <= ex_d;
    end
  end

  // Forwarding selects; EX/MEM beats MEM/WB when both match
  always_comb begin
    mem_src   = mem_q.valid & mem_q.reg_write & (mem_q.rd != ZR);
    wb_src    = wb_q.valid & wb_q.reg_write & (wb_q.rd != ZR);
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (ex_q.valid) begin
      if (ex_q.use_rn & mem_src & (mem_q.rd == ex_q.rn)) begin
        fwd_a_sel = SEL_MEM;
      end else if (wb_src & (wb_q.rd == ex_q.rn)) begin
        fwd_a_sel = SEL_WB;
      end
      if (ex_q.use_rm & mem_src & (mem_q.rd == ex_q.rm)) begin
        fwd_b_sel = SEL_MEM;
      end else if (wb_src & (wb_q.rd == ex_q.rm)) begin
        fwd_b_sel = SEL_WB;
      end
    end
  end

  assign ex_bubble = ~ex_q.valid;

`ifdef FWD_HAZARD_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
      fwd_count   <= 32'd0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (((fwd_a_sel != SEL_RF) || (fwd_b_sel != SEL_RF)) &&
          (fwd_count != 32'hFFFF_FFFF)) begin
        fwd_count <= fwd_count + 32'd1;
      end
    end
  end
`else
  // Core-only build: no statistics state
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed, table-driven bench for fwd_hazard_ctrl. Each table row holds the
// ID-stage inputs driven for one cycle and the outputs expected during that
// same cycle (before the next rising edge).
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_use_rn;
  logic       id_use_rm;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic       ex_bubble;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] fwd_count;
`endif

  int total;
  int bad;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .ZERO_REG(31)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_use_rn    (id_use_rn),
    .id_use_rm    (id_use_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .ex_bubble    (ex_bubble)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       v;
    logic [4:0] rn;
    logic       urn;
    logic [4:0] rm;
    logic       urm;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    logic       ebub;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t alu(logic rst, logic fl, logic [4:0] rn, logic [4:0] rm,
                               logic [4:0] rd, logic [1:0] ea, logic [1:0] eb,
                               logic es, logic ebub);
    vec_t r;
    r = '{rst: rst, fl: fl, v: 1'b1, rn: rn, urn: 1'b1, rm: rm, urm: 1'b1, rd: rd,
          rw: 1'b1, mr: 1'b0, ea: ea, eb: eb, es: es, ebub: ebub};
    return r;
  endfunction

  function automatic vec_t ldr(logic rst, logic fl, logic [4:0] rn, logic [4:0] rd,
                               logic [1:0] ea, logic [1:0] eb, logic es, logic ebub);
    vec_t r;
    r = '{rst: rst, fl: fl, v: 1'b1, rn: rn, urn: 1'b1, rm: 5'd0, urm: 1'b0, rd: rd,
          rw: 1'b1, mr: 1'b1, ea: ea, eb: eb, es: es, ebub: ebub};
    return r;
  endfunction

  function automatic vec_t nop(logic [1:0] ea, logic [1:0] eb, logic es, logic ebub);
    vec_t r;
    r = '{rst: 1'b0, fl: 1'b0, v: 1'b0, rn: 5'd0, urn: 1'b0, rm: 5'd0, urm: 1'b0,
          rd: 5'd0, rw: 1'b0, mr: 1'b0, ea: ea, eb: eb, es: es, ebub: ebub};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    reset        = r.rst;
    flush        = r.fl;
    id_valid     = r.v;
    id_rn        = r.rn;
    id_use_rn    = r.urn;
    id_rm        = r.rm;
    id_use_rm    = r.urm;
    id_rd        = r.rd;
    id_reg_write = r.rw;
    id_mem_read  = r.mr;
  endtask

  initial begin
    vec_t r;
    int exp_sc;
    int exp_fc;
    int nstall;
    total  = 0;
    bad    = 0;
    exp_sc = 0;
    exp_fc = 0;

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    vecs.push_back(alu(0, 0, 5'd2, 5'd3, 5'd1, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd1, 5'd5, 5'd4, 2'd0, 2'd0, 0, 0));
    vecs.push_back(nop(2'd2, 2'd0, 0, 0));
    vecs.push_back(nop(2'd0, 2'd0, 0, 1));
    // ADD X1 ; NOP ; ORR X6,X7,X1
    vecs.push_back(alu(0, 0, 5'd2, 5'd3, 5'd1, 2'd0, 2'd0, 0, 1));
    vecs.push_back(nop(2'd0, 2'd0, 0, 0));
    vecs.push_back(alu(0, 0, 5'd7, 5'd1, 5'd6, 2'd0, 2'd0, 0, 1));
    vecs.push_back(nop(2'd0, 2'd1, 0, 0));
    // ADD X1 ; ADD X1 ; AND X8,X1,X1
    vecs.push_back(alu(0, 0, 5'd2, 5'd3, 5'd1, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd2, 5'd3, 5'd1, 2'd0, 2'd0, 0, 0));
    vecs.push_back(alu(0, 0, 5'd1, 5'd1, 5'd8, 2'd0, 2'd0, 0, 0));
    vecs.push_back(nop(2'd2, 2'd2, 0, 0));
    // LDUR X9,[X2] ; ADD X10,X9,X9 (held one cycle by the stall)
    vecs.push_back(ldr(0, 0, 5'd2, 5'd9, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd9, 5'd9, 5'd10, 2'd0, 2'd0, 1, 0));
    vecs.push_back(alu(0, 0, 5'd9, 5'd9, 5'd10, 2'd0, 2'd0, 0, 1));
    vecs.push_back(nop(2'd1, 2'd1, 0, 0));
    // ADD XZR,X1,X2 ; SUB X3,XZR,X4
    vecs.push_back(alu(0, 0, 5'd1, 5'd2, 5'd31, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd31, 5'd4, 5'd3, 2'd0, 2'd0, 0, 0));
    vecs.push_back(nop(2'd0, 2'd0, 0, 0));
    // LDUR XZR ; ADD X5,X31,X31
    vecs.push_back(ldr(0, 0, 5'd2, 5'd31, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd31, 5'd31, 5'd5, 2'd0, 2'd0, 0, 0));
    vecs.push_back(nop(2'd0, 2'd0, 0, 0));
    // Load-use pair with flush on the consumer
    vecs.push_back(ldr(0, 0, 5'd2, 5'd9, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 1, 5'd9, 5'd9, 5'd10, 2'd0, 2'd0, 0, 0));
    vecs.push_back(nop(2'd0, 2'd0, 0, 1));
    // Flushed writer of X1 must not forward to the next user of X1
    vecs.push_back(alu(0, 1, 5'd2, 5'd3, 5'd1, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(0, 0, 5'd1, 5'd1, 5'd4, 2'd0, 2'd0, 0, 1));
    vecs.push_back(nop(2'd0, 2'd0, 0, 0));
    // Reset asserted during a stall cycle discards the load
    vecs.push_back(ldr(0, 0, 5'd2, 5'd9, 2'd0, 2'd0, 0, 1));
    vecs.push_back(alu(1, 0, 5'd9, 5'd9, 5'd1, 2'd0, 2'd0, 1, 0));
    vecs.push_back(alu(0, 0, 5'd9, 5'd9, 5'd1, 2'd0, 2'd0, 0, 1));
    vecs.push_back(nop(2'd0, 2'd0, 0, 0));

    // Initial reset
    drive(nop(2'd0, 2'd0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_sel_a", 32'(fwd_a_sel), 32'd0);
    chk("reset_sel_b", 32'(fwd_b_sel), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_ex_bubble", 32'(ex_bubble), 32'd1);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      @(posedge clk);
      #1 drive(r);
      @(negedge clk);
      chk($sformatf("row%0d_sel_a", i), 32'(fwd_a_sel), 32'(r.ea));
      chk($sformatf("row%0d_sel_b", i), 32'(fwd_b_sel), 32'(r.eb));
      chk($sformatf("row%0d_stall", i), 32'(stall), 32'(r.es));
      chk($sformatf("row%0d_ex_bubble", i), 32'(ex_bubble), 32'(r.ebub));
`ifdef FWD_HAZARD_STATS_EN
      chk($sformatf("row%0d_stall_count", i), stall_count, 32'(exp_sc));
      chk($sformatf("row%0d_fwd_count", i), fwd_count, 32'(exp_fc));
`endif
      if (r.rst) begin
        exp_sc = 0;
        exp_fc = 0;
      end else begin
        exp_sc += int'(r.es);
        exp_fc += ((r.ea != 2'd0) || (r.eb != 2'd0)) ? 1 : 0;
      end
    end

    // Hand sequence: LDUR X12 then a consumer held in ID for three cycles
    @(posedge clk);
    #1 drive(ldr(0, 0, 5'd2, 5'd12, 2'd0, 2'd0, 0, 0));
    nstall = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 drive(alu(0, 0, 5'd12, 5'd3, 5'd13, 2'd0, 2'd0, 0, 0));
      @(negedge clk);
      if (stall === 1'b1) nstall++;
      if (c == 1) chk("seq_bubble_after_stall", 32'(ex_bubble), 32'd1);
      if (c == 2) begin
        chk("seq_consumer_sel_a", 32'(fwd_a_sel), 32'd1);
        chk("seq_consumer_sel_b", 32'(fwd_b_sel), 32'd0);
      end
    end
    chk("seq_stall_cycles", 32'(nstall), 32'd1);

    // Final reset returns everything to the idle state
    @(posedge clk);
    #1 drive(nop(2'd0, 2'd0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("final_sel_a", 32'(fwd_a_sel), 32'd0);
    chk("final_sel_b", 32'(fwd_b_sel), 32'd0);
    chk("final_stall", 32'(stall), 32'd0);
    chk("final_ex_bubble", 32'(ex_bubble), 32'd1);
`ifdef FWD_HAZARD_STATS_EN
    chk("final_stall_count", stall_count, 32'd0);
    chk("final_fwd_count", fwd_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
